// File: rtl/secuenciador_inicializar.sv
// RTC initialisation sequencer.
// Walks the decoder through step codes 1..8, a timed pause on code 9, then
// 10 and 11. Each bus step is handed to the bus-cycle controller with a
// one-cycle go pulse, and the sequencer waits for bus_done. A missing
// bus_done aborts the run and raises a sticky error flag. Every output is
// registered.
module secuenciador_inicializar #(
  parameter logic [15:0] WAIT_CYCLES    = 16'd1000,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd255
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       bus_done,
  output logic [3:0] ctrl_I,
  output logic       go,
  output logic       busy,
  output logic       done,
  output logic       error
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE    = 3'd1,
    WAIT_ACK = 3'd2,
    PAUSE    = 3'd3,
    FINISH   = 3'd4
  } state_t;

  // Step codes with special meaning in the walk.
  localparam logic [3:0] STEP_IDLE       = 4'd0;
  localparam logic [3:0] STEP_FIRST      = 4'd1;
  localparam logic [3:0] STEP_PRE_PAUSE  = 4'd8;
  localparam logic [3:0] STEP_PAUSE      = 4'd9;
  localparam logic [3:0] STEP_POST_PAUSE = 4'd10;
  localparam logic [3:0] STEP_LAST       = 4'd11;

  // A zero length would mean "never". Both windows are clamped to at least one cycle.
  localparam logic [15:0] PAUSE_LEN = (WAIT_CYCLES == 16'd0) ? 16'd1 : WAIT_CYCLES;
  localparam logic [15:0] TO_LEN    = (TIMEOUT_CYCLES == 16'd0) ? 16'd1 : TIMEOUT_CYCLES;

  state_t      state, state_n;
  logic [3:0]  ctrl_n;
  logic        go_n, busy_n, done_n, error_n;
  logic [15:0] to_cnt, to_cnt_n;
  logic [15:0] pause_cnt, pause_cnt_n;
  logic        to_last, pause_last;

  // The counters count from 0. The last cycle of each window is therefore LEN-1,
  // and a counter never rises above its window length.
  assign to_last    = (to_cnt == TO_LEN - 16'd1);
  assign pause_last = (pause_cnt == PAUSE_LEN - 16'd1);

  // Next-state and next-output logic. Outputs are computed one cycle early and registered.
  always_comb begin
    state_n     = state;
    ctrl_n      = ctrl_I;
    go_n        = 1'b0;
    busy_n      = busy;
    done_n      = 1'b0;
    error_n     = error;
    to_cnt_n    = to_cnt;
    pause_cnt_n = pause_cnt;
    case (state)
      IDLE: begin
        ctrl_n = STEP_IDLE;
        busy_n = 1'b0;
        if (start) begin
          state_n = ISSUE;
          ctrl_n  = STEP_FIRST;
          go_n    = 1'b1;
          busy_n  = 1'b1;
          error_n = 1'b0;
        end
      end
      // go is high during this cycle. bus_done is not looked at here.
      ISSUE: begin
        state_n  = WAIT_ACK;
        to_cnt_n = 16'd0;
      end
      WAIT_ACK: begin
        if (bus_done) begin
          // bus_done is tested first, so it wins over a timeout in the same cycle.
          to_cnt_n = 16'd0;
          if (ctrl_I == STEP_PRE_PAUSE) begin
            state_n     = PAUSE;
            ctrl_n      = STEP_PAUSE;
            pause_cnt_n = 16'd0;
          end else if (ctrl_I == STEP_LAST) begin
            state_n = FINISH;
            ctrl_n  = STEP_IDLE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end else begin
            state_n = ISSUE;
            ctrl_n  = ctrl_I + 4'd1;
            go_n    = 1'b1;
          end
        end else if (to_last) begin
          state_n  = IDLE;
          ctrl_n   = STEP_IDLE;
          busy_n   = 1'b0;
          error_n  = 1'b1;
          to_cnt_n = 16'd0;
        end else begin
          to_cnt_n = to_cnt + 16'd1;
        end
      end
      PAUSE: begin
        if (pause_last) begin
          state_n     = ISSUE;
          ctrl_n      = STEP_POST_PAUSE;
          go_n        = 1'b1;
          pause_cnt_n = 16'd0;
        end else begin
          pause_cnt_n = pause_cnt + 16'd1;
        end
      end
      // done is high during this cycle. start is only accepted after the return to IDLE.
      FINISH: begin
        state_n = IDLE;
        ctrl_n  = STEP_IDLE;
        busy_n  = 1'b0;
      end
      default: begin
        state_n     = IDLE;
        ctrl_n      = STEP_IDLE;
        busy_n      = 1'b0;
        to_cnt_n    = 16'd0;
        pause_cnt_n = 16'd0;
      end
    endcase
  end

  // State, counters and registered outputs. Reset clears all of them asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      ctrl_I    <= STEP_IDLE;
      go        <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      to_cnt    <= 16'd0;
      pause_cnt <= 16'd0;
    end else begin
      state     <= state_n;
      ctrl_I    <= ctrl_n;
      go        <= go_n;
      busy      <= busy_n;
      done      <= done_n;
      error     <= error_n;
      to_cnt    <= to_cnt_n;
      pause_cnt <= pause_cnt_n;
    end
  end

endmodule

// File: tb/tb_secuenciador_inicializar.sv
// Randomised self-checking bench for secuenciador_inicializar (WAIT=4, TIMEOUT=16).
// The reference model builds a per-cycle expected trace from step bus_done delays.
// Each trace entry is {ctrl_I, go, busy, done, error}.
module tb_secuenciador_inicializar;
  localparam int W    = 4;
  localparam int TO   = 16;
  localparam int MAXC = 400;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       start = 1'b0;
  logic       bus_done = 1'b0;
  logic [3:0] ctrl_I;
  logic       go, busy, done, error;
  logic [7:0] obs;

  int tests = 0;
  int fails = 0;

  logic [7:0] ev [MAXC];
  bit         st [MAXC];
  bit         bd [MAXC];
  bit         wa [MAXC];
  int         dly [16];
  int         n;
  int         stp [10] = '{1, 2, 3, 4, 5, 6, 7, 8, 10, 11};

  secuenciador_inicializar #(.WAIT_CYCLES(16'd4), .TIMEOUT_CYCLES(16'd16)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .bus_done(bus_done),
    .ctrl_I(ctrl_I), .go(go), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;
  assign obs = {ctrl_I, go, busy, done, error};

  // Model. Cycle 0 starts in IDLE, start is seen in cycle s0, and each go is
  // answered dly[step] cycles later. A delay above TO means no answer comes.
  task automatic build(input int s0, input bit err0, input bit hold, input bit spur);
    int t, b, d, e;
    bit ab;
    t = s0 + 1; e = 0; ab = 0;
    for (int i = 0; i < MAXC; i++) begin
      ev[i] = {4'd0, 3'b000, err0}; st[i] = hold && (i >= s0); bd[i] = 0; wa[i] = 0;
    end
    st[s0] = 1;
    for (int k = 0; k < 10 && !ab; k++) begin
      ev[t] = {4'(stp[k]), 4'b1100};
      d = dly[stp[k]];
      if (d > TO) begin
        for (int j = 1; j <= TO; j++) begin ev[t+j] = {4'(stp[k]), 4'b0100}; wa[t+j] = 1; end
        e = t + TO + 1; ab = 1;
      end else begin
        for (int j = 1; j <= d; j++) begin ev[t+j] = {4'(stp[k]), 4'b0100}; wa[t+j] = 1; end
        b = t + d; bd[b] = 1;
        if (stp[k] == 8) begin
          for (int j = 1; j <= W; j++) ev[b+j] = {4'd9, 4'b0100};
          t = b + W + 1;
        end else if (stp[k] == 11) begin
          ev[b+1] = {4'd0, 4'b0010}; e = b + 2;
        end else t = b + 1;
      end
    end
    for (int i = e; i < MAXC; i++) ev[i] = {4'd0, 3'b000, ab};
    n = e + 1;
    if (hold) begin ev[e+1] = {4'd1, 4'b1100}; n = e + 2; end
    if (spur) for (int i = 0; i < n; i++) if (!wa[i] && $urandom_range(0, 2) == 0) bd[i] = 1;
  endtask

  task automatic set_dly(input int v);
    for (int k = 0; k < 16; k++) dly[k] = v;
  endtask

  task automatic rand_dly();
    for (int k = 0; k < 16; k++) dly[k] = $urandom_range(1, TO);
  endtask

  task automatic drive(input int i);
    @(posedge clk); #1;
    start = st[i]; bus_done = bd[i];
    @(negedge clk);
  endtask

  task automatic do_reset();
    start = 0; bus_done = 0;
    @(negedge clk); reset_n = 0;
    repeat (2) @(negedge clk);
    reset_n = 1;
  endtask

  task automatic test_reset();
    start = 1; bus_done = 1; reset_n = 0;
    repeat (3) begin
      @(negedge clk); tests++;
      if (obs !== 8'h00) begin fails++; $display("FAIL reset_hold got=%h want=00", obs); end
    end
    reset_n = 1; bus_done = 0;
    #2; tests++;
    if (obs !== 8'h00) begin fails++; $display("FAIL reset_release_early got=%h want=00", obs); end
    @(negedge clk); tests++;
    if (obs !== 8'h1c) begin fails++; $display("FAIL reset_first_start got=%h want=1c", obs); end
    do_reset();
  endtask

  task automatic test_nominal();
    int gos, dns;
    gos = 0; dns = 0;
    set_dly(3); build(1, 0, 0, 0);
    for (int i = 0; i < n; i++) begin
      drive(i); tests++;
      gos += int'(go); dns += int'(done);
      if (obs !== ev[i]) begin fails++; $display("FAIL nominal cyc=%0d got=%h want=%h", i, obs, ev[i]); end
    end
    start = 0; bus_done = 0;
    tests++;
    if (gos != 10) begin fails++; $display("FAIL nominal_go_count got=%0d want=10", gos); end
    tests++;
    if (dns != 1) begin fails++; $display("FAIL nominal_done_count got=%0d want=1", dns); end
  endtask

  task automatic test_min_latency();
    int dc;
    dc = -1;
    set_dly(1); build(2, 0, 0, 0);
    for (int i = 0; i < n; i++) begin
      drive(i); tests++;
      if (done === 1'b1 && dc < 0) dc = i;
      if (obs !== ev[i]) begin fails++; $display("FAIL min_latency cyc=%0d got=%h want=%h", i, obs, ev[i]); end
    end
    start = 0; bus_done = 0;
    tests++;
    if (dc != 27) begin fails++; $display("FAIL min_latency_done_cycle got=%0d want=27", dc); end
  endtask

  task automatic test_spurious();
    set_dly(2); build(1, 0, 0, 1);
    for (int i = 0; i < n; i++) begin
      drive(i); tests++;
      if (obs !== ev[i]) begin fails++; $display("FAIL spurious cyc=%0d got=%h want=%h", i, obs, ev[i]); end
    end
    start = 0; bus_done = 0;
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      rand_dly(); build($urandom_range(0, 5), 0, 0, $urandom_range(0, 1));
      for (int i = 0; i < n; i++) begin
        drive(i); tests++;
        if (obs !== ev[i]) begin fails++; $display("FAIL random%0d cyc=%0d got=%h want=%h", r, i, obs, ev[i]); end
      end
      start = 0; bus_done = 0;
    end
  endtask

  task automatic test_timeout();
    rand_dly(); dly[5] = 99; build(2, 0, 0, 1);
    for (int i = 0; i < n; i++) begin
      drive(i); tests++;
      if (obs !== ev[i]) begin fails++; $display("FAIL timeout cyc=%0d got=%h want=%h", i, obs, ev[i]); end
    end
    start = 0; bus_done = 0;
  endtask

  task automatic test_error_clear();
    set_dly(2); build(3, 1, 0, 0);
    for (int i = 0; i < n; i++) begin
      drive(i); tests++;
      if (obs !== ev[i]) begin fails++; $display("FAIL error_clear cyc=%0d got=%h want=%h", i, obs, ev[i]); end
    end
    start = 0; bus_done = 0;
  endtask

  task automatic test_timeout_edge();
    set_dly(TO); build(0, 0, 0, 0);
    for (int i = 0; i < n; i++) begin
      drive(i); tests++;
      if (obs !== ev[i]) begin fails++; $display("FAIL timeout_edge cyc=%0d got=%h want=%h", i, obs, ev[i]); end
    end
    start = 0; bus_done = 0;
  endtask

  task automatic test_reset_mid();
    bit hit;
    hit = 0;
    set_dly(3); build(1, 0, 0, 0);
    for (int i = 0; i < n && !hit; i++) begin
      drive(i); tests++;
      if (obs !== ev[i]) begin fails++; $display("FAIL reset_mid cyc=%0d got=%h want=%h", i, obs, ev[i]); end
      if (wa[i] && ev[i][7:4] == 4'd6) begin
        hit = 1;
        #2 reset_n = 0;
        #1; tests++;
        if (obs !== 8'h00) begin fails++; $display("FAIL reset_mid_async got=%h want=00", obs); end
      end
    end
    tests++;
    if (!hit) begin fails++; $display("FAIL reset_mid_reach got=0 want=1"); end
    start = 0; bus_done = 1;
    @(negedge clk); reset_n = 1;
    @(negedge clk); tests++;
    if (obs !== 8'h00) begin fails++; $display("FAIL reset_mid_idle got=%h want=00", obs); end
    bus_done = 0; start = 1;
    @(negedge clk); tests++;
    if (obs !== 8'h1c) begin fails++; $display("FAIL reset_mid_restart got=%h want=1c", obs); end
    do_reset();
  endtask

  task automatic test_hold_start();
    rand_dly(); build(0, 0, 1, 1);
    for (int i = 0; i < n; i++) begin
      drive(i); tests++;
      if (obs !== ev[i]) begin fails++; $display("FAIL hold_start cyc=%0d got=%h want=%h", i, obs, ev[i]); end
    end
    do_reset();
  endtask

  initial begin
    #1;
    test_reset();
    test_nominal();
    test_min_latency();
    test_spurious();
    test_random();
    test_timeout();
    test_error_clear();
    test_timeout_edge();
    test_reset_mid();
    test_hold_start();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
